// File: rtl/cpu_pkg.sv
// Shared types and default sizes for the CPU run-control slice.
package cpu_pkg;

  localparam int unsigned PC_W_DEF       = 10;
  localparam int unsigned OFF_W_DEF      = 8;
  localparam int unsigned START_ADDR_DEF = 0;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned MAX_CYCLES_DEF = 32'h0000_FFFF;

  // Launch handshake state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_LOAD   = 2'd1,
    PC_INC    = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/run_ctrl_pc_next.sv
// Combinational next-PC: hold, load start address, increment or signed relative branch.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned OFF_W      = OFF_W_DEF,
  parameter int unsigned START_ADDR = START_ADDR_DEF
) (
  input  logic [PC_W-1:0]  i_pc,
  input  pc_sel_t          i_sel,
  input  logic [OFF_W-1:0] i_off,
  output logic [PC_W-1:0]  o_pc_next_c
);

  logic [PC_W-1:0] w_off_ext;

  // Sign-extend the branch offset to PC width; the add wraps modulo 2^PC_W
  assign w_off_ext = PC_W'($signed(i_off));

  // Select the next PC value
  always_comb begin
    o_pc_next_c = i_pc;
    unique case (i_sel)
      PC_HOLD:   o_pc_next_c = i_pc;
      PC_LOAD:   o_pc_next_c = PC_W'(START_ADDR);
      PC_INC:    o_pc_next_c = i_pc + PC_W'(1);
      PC_BRANCH: o_pc_next_c = i_pc + w_off_ext;
      default:   o_pc_next_c = i_pc;
    endcase
  end

endmodule

// File: rtl/run_ctrl.sv
// Start/Ack program-launch responder: load phase, PC sequencing, cycle count and watchdog.
module run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned OFF_W      = OFF_W_DEF,
  parameter int unsigned START_ADDR = START_ADDR_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic [OFF_W-1:0] BranchOff,
  output logic             Ack,
  output logic             RunEn,
  output logic [PC_W-1:0]  PC,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

  run_state_t       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_timeout;

  pc_sel_t          w_pc_sel;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wd_hit;

  // Saturating count for this RUN cycle and the watchdog compare on it
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_wd_hit  = (MAX_CYCLES != 32'd0) && (w_cnt_inc == CNT_W'(MAX_CYCLES));

  // PC source: Start always reloads; only an uninterrupted RUN cycle advances
  always_comb begin
    w_pc_sel = PC_HOLD;
    if (Start) begin
      w_pc_sel = PC_LOAD;
    end else if ((r_state == RUN) && !Halt && !w_wd_hit) begin
      w_pc_sel = BranchEn ? PC_BRANCH : PC_INC;
    end
  end

  pc_next #(
    .PC_W       (PC_W),
    .OFF_W      (OFF_W),
    .START_ADDR (START_ADDR)
  ) u_pc_next (
    .i_pc        (r_pc),
    .i_sel       (w_pc_sel),
    .i_off       (BranchOff),
    .o_pc_next_c (w_pc_next)
  );

  // Handshake FSM with registered PC, counter, Ack and Timeout
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_pc      <= PC_W'(START_ADDR);
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (Start) begin
        r_state   <= LOAD;
        r_cnt     <= '0;
        r_ack     <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: r_state <= IDLE;
          LOAD: r_state <= RUN;
          RUN: begin
            r_cnt <= w_cnt_inc;
            if (Halt) begin
              r_state <= DONE;
              r_ack   <= 1'b1;
            end else if (w_wd_hit) begin
              r_state   <= DONE;
              r_ack     <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
          DONE: r_state <= DONE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign Ack        = r_ack;
  assign RunEn      = (r_state == RUN);
  assign PC         = r_pc;
  assign CycleCount = r_cnt;
  assign Timeout    = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a per-cycle reference pushes expected outputs, compared after each edge.
module tb_run_ctrl;
  import cpu_pkg::*;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFF_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAXC  = 20;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Halt;
  logic             BranchEn;
  logic [OFF_W-1:0] BranchOff;
  logic             Ack;
  logic             RunEn;
  logic [PC_W-1:0]  PC;
  logic [CNT_W-1:0] CycleCount;
  logic             Timeout;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic             ack;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } exp_t;

  exp_t q_exp[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  run_state_t       m_state;
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ack;
  logic             m_to;

  run_ctrl #(
    .PC_W       (PC_W),
    .OFF_W      (OFF_W),
    .START_ADDR (0),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAXC)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .BranchOff  (BranchOff),
    .Ack        (Ack),
    .RunEn      (RunEn),
    .PC         (PC),
    .CycleCount (CycleCount),
    .Timeout    (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge from the spec's rules
  task automatic model_step(input logic rst, input logic st, input logic h,
                            input logic be, input logic [OFF_W-1:0] off);
    logic [CNT_W-1:0] c1;
    logic [PC_W-1:0]  ext;
    if (!rst) begin
      m_state = IDLE; m_pc = '0; m_cnt = '0; m_ack = 1'b0; m_to = 1'b0;
    end else if (st) begin
      m_state = LOAD; m_pc = '0; m_cnt = '0; m_ack = 1'b0; m_to = 1'b0;
    end else begin
      case (m_state)
        LOAD: m_state = RUN;
        RUN: begin
          c1 = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          m_cnt = c1;
          if (h) begin
            m_state = DONE; m_ack = 1'b1;
          end else if (c1 == CNT_W'(MAXC)) begin
            m_state = DONE; m_ack = 1'b1; m_to = 1'b1;
          end else if (be) begin
            ext  = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
            m_pc = m_pc + ext;
          end else begin
            m_pc = m_pc + 10'd1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge
  task automatic cyc(input logic rst, input logic st, input logic h,
                     input logic be, input logic [OFF_W-1:0] off);
    exp_t e;
    exp_t g;
    @(negedge Clk);
    Reset = rst; Start = st; Halt = h; BranchEn = be; BranchOff = off;
    model_step(rst, st, h, be, off);
    e.pc = m_pc; e.ack = m_ack; e.run = (m_state == RUN); e.cnt = m_cnt; e.to = m_to;
    q_exp.push_back(e);
    @(posedge Clk);
    #1;
    g = q_exp.pop_front();
    check("pc",      32'(PC),         32'(g.pc));
    check("ack",     32'(Ack),        32'(g.ack));
    check("run_en",  32'(RunEn),      32'(g.run));
    check("cyc_cnt", 32'(CycleCount), 32'(g.cnt));
    check("timeout", 32'(Timeout),    32'(g.to));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset = 1'b0; Start = 1'b1; Halt = 1'b0; BranchEn = 1'b0; BranchOff = '0;
    m_state = IDLE; m_pc = '0; m_cnt = '0; m_ack = 1'b0; m_to = 1'b0;

    // Reset with Start high
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_run", 32'(RunEn), 32'd0);

    // Load phase, then run five cycles with Halt on the fifth
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("load_pc", 32'(PC), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("run_first_pc", 32'(PC), 32'd0);
    run_n(4);
    check("run_pc4", 32'(PC), 32'd4);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("halt_ack", 32'(Ack), 32'd1);
    check("halt_pc", 32'(PC), 32'd4);
    check("halt_cnt", 32'(CycleCount), 32'd5);
    check("halt_to", 32'(Timeout), 32'd0);
    // DONE ignores Halt/Branch
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h10);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hF0);

    // Start in DONE: Ack drops, counter clears
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("redo_ack", 32'(Ack), 32'd0);
    check("redo_cnt", 32'(CycleCount), 32'd0);

    // Branch backwards, wrap-around forward branch and increment wrap
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(5);
    check("br_pc5", 32'(PC), 32'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFD);
    check("br_back", 32'(PC), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFA);
    check("br_1020", 32'(PC), 32'd1020);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h07);
    check("br_wrap", 32'(PC), 32'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFC);
    check("br_1023", 32'(PC), 32'd1023);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("inc_wrap", 32'(PC), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("br_halt_cnt", 32'(CycleCount), 32'd11);

    // Watchdog expiry without Halt
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(20);
    check("wd_to", 32'(Timeout), 32'd1);
    check("wd_cnt", 32'(CycleCount), 32'd20);
    check("wd_ack", 32'(Ack), 32'd1);
    check("wd_run", 32'(RunEn), 32'd0);

    // Halt coincident with the watchdog limit wins
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("wd_clr_to", 32'(Timeout), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(19);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("wdh_to", 32'(Timeout), 32'd0);
    check("wdh_cnt", 32'(CycleCount), 32'd20);
    check("wdh_ack", 32'(Ack), 32'd1);

    // Abort mid-RUN at PC=7, then a clean rerun
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(7);
    check("abort_pc7", 32'(PC), 32'd7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("abort_pc", 32'(PC), 32'd0);
    check("abort_ack", 32'(Ack), 32'd0);
    check("abort_run", 32'(RunEn), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("rerun_ack", 32'(Ack), 32'd1);
    check("rerun_cnt", 32'(CycleCount), 32'd4);

    // Reset mid-RUN
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_n(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("mid_rst_pc", 32'(PC), 32'd0);
    check("mid_rst_cnt", 32'(CycleCount), 32'd0);
    check("mid_rst_run", 32'(RunEn), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
